// File: rtl/video_timing_gen_pkg.sv
// Shared types and constants for the video timing generator.
// Pattern codes, the marker colour, the frame-config bundle and colour helpers.
package video_timing_gen_pkg;

    localparam int CNT_W = 12;
    localparam int CRD_W = 10;

    typedef enum logic [1:0] {
        PAT_BARS  = 2'd0,
        PAT_RAMP  = 2'd1,
        PAT_CHECK = 2'd2,
        PAT_SOLID = 2'd3
    } pat_e;

    localparam logic [23:0] MARKER_RGB = 24'hFF0000;
    localparam logic [23:0] RGB_WHITE  = 24'hFFFFFF;
    localparam logic [23:0] RGB_BLACK  = 24'h000000;

    // Per-frame settings, latched at the frame boundary.
    typedef struct packed {
        pat_e             pat;
        logic [23:0]      solid;
        logic             mk_en;
        logic [CRD_W-1:0] mk_x;
        logic [CRD_W-1:0] mk_y;
    } cfg_t;

    // Bar 0 is white, bar 7 is black; channel bits follow the inverted index.
    function automatic logic [23:0] bar_rgb(input logic [2:0] bar);
        logic [2:0] c;
        c = ~bar;
        return {{8{c[2]}}, {8{c[1]}}, {8{c[0]}}};
    endfunction

    function automatic logic [23:0] grey_rgb(input logic [7:0] v);
        return {v, v, v};
    endfunction

endpackage

// File: rtl/video_timing_gen_pattern.sv
// Registered colour generation for active video.
// Applies the marker overlay on top of the selected test pattern.
module video_timing_gen_pattern
    import video_timing_gen_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic             i_active,
    input  logic [CRD_W-1:0] i_x,
    input  logic [CRD_W-1:0] i_y,
    input  logic [2:0]       i_bar,
    input  cfg_t             i_cfg,
    output logic [23:0]      o_rgb
);

    logic        w_mark;
    logic [23:0] w_rgb;
    logic [23:0] r_rgb;

    always_comb begin
        w_mark = i_cfg.mk_en &&
                 ((i_x == i_cfg.mk_x) || (i_y == i_cfg.mk_y));
        w_rgb  = RGB_BLACK;
        if (!i_active) begin
            w_rgb = RGB_BLACK;
        end else if (w_mark) begin
            w_rgb = MARKER_RGB;
        end else begin
            unique case (i_cfg.pat)
                PAT_BARS:  w_rgb = bar_rgb(i_bar);
                PAT_RAMP:  w_rgb = grey_rgb(i_x[7:0]);
                PAT_CHECK: w_rgb = (i_x[3] ^ i_y[3]) ? RGB_WHITE : RGB_BLACK;
                PAT_SOLID: w_rgb = i_cfg.solid;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rgb <= RGB_BLACK;
        end else if (i_ce) begin
            r_rgb <= w_rgb;
        end
    end

    assign o_rgb = r_rgb;

endmodule

// File: rtl/video_timing_gen.sv
// Raster timing source: counters, sync decode, per-frame config latching
// and one-cycle output alignment with the pattern generator.
module video_timing_gen
    import video_timing_gen_pkg::*;
#(
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64,
    parameter int H_FP   = 4,
    parameter int H_SYNC = 8,
    parameter int H_BP   = 4,
    parameter int V_FP   = 1,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 1,
    parameter bit HS_POL = 1'b1,
    parameter bit VS_POL = 1'b1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_ce,
    input  logic [1:0]       i_pattern_sel,
    input  logic [23:0]      i_solid_rgb,
    input  logic             i_marker_en,
    input  logic [CRD_W-1:0] i_marker_x,
    input  logic [CRD_W-1:0] i_marker_y,
    output logic             o_de,
    output logic             o_hsync,
    output logic             o_vsync,
    output logic [7:0]       o_r,
    output logic [7:0]       o_g,
    output logic [7:0]       o_b,
    output logic [CRD_W-1:0] o_x,
    output logic [CRD_W-1:0] o_y,
    output logic             o_frame_start
);

    localparam int H_TOTAL = IMG_W + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = IMG_H + V_FP + V_SYNC + V_BP;
    localparam int BAR_W   = IMG_W / 8;

    localparam logic [CNT_W-1:0] ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(IMG_H);
    localparam logic [CNT_W-1:0] HS_ON  = CNT_W'(IMG_W + H_FP);
    localparam logic [CNT_W-1:0] HS_OFF = CNT_W'(IMG_W + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] VS_ON  = CNT_W'(IMG_H + V_FP);
    localparam logic [CNT_W-1:0] VS_OFF = CNT_W'(IMG_H + V_FP + V_SYNC);

    localparam logic [CRD_W-1:0] BAR_LAST = CRD_W'(BAR_W - 1);
    localparam logic [CRD_W-1:0] CRD_ONE  = CRD_W'(1);

    logic [CNT_W-1:0] r_hcnt;
    logic [CNT_W-1:0] r_vcnt;
    logic [CRD_W-1:0] r_bar_sub;
    logic [2:0]       r_bar;
    cfg_t             r_cfg;

    logic             r_de;
    logic             r_hs;
    logic             r_vs;
    logic [CRD_W-1:0] r_x;
    logic [CRD_W-1:0] r_y;
    logic             r_fs;

    logic             w_h_wrap;
    logic             w_v_wrap;
    logic             w_active;
    logic             w_frame0;
    logic             w_hs_on;
    logic             w_vs_on;
    logic             w_bar_step;
    logic [CRD_W-1:0] w_x;
    logic [CRD_W-1:0] w_y;
    cfg_t             w_cfg_live;
    cfg_t             w_cfg;
    logic [23:0]      w_rgb;

    always_comb begin
        w_h_wrap   = (r_hcnt == H_LAST);
        w_v_wrap   = (r_vcnt == V_LAST);
        w_active   = (r_hcnt < H_ACT) && (r_vcnt < V_ACT);
        w_frame0   = (r_hcnt == '0) && (r_vcnt == '0);
        w_hs_on    = (r_hcnt >= HS_ON) && (r_hcnt < HS_OFF);
        w_vs_on    = (r_vcnt >= VS_ON) && (r_vcnt < VS_OFF);
        w_bar_step = (r_bar_sub == BAR_LAST);
        w_x        = w_active ? r_hcnt[CRD_W-1:0] : '0;
        w_y        = w_active ? r_vcnt[CRD_W-1:0] : '0;
    end

    assign w_cfg_live = '{
        pat:   pat_e'(i_pattern_sel),
        solid: i_solid_rgb,
        mk_en: i_marker_en,
        mk_x:  i_marker_x,
        mk_y:  i_marker_y
    };

    // Pixel (0,0) already uses the settings being latched for the new frame.
    assign w_cfg = w_frame0 ? w_cfg_live : r_cfg;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (i_ce) begin
            if (w_h_wrap) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_wrap ? '0 : r_vcnt + ONE;
            end else begin
                r_hcnt <= r_hcnt + ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bar_sub <= '0;
            r_bar     <= '0;
        end else if (i_ce) begin
            if (w_h_wrap) begin
                r_bar_sub <= '0;
                r_bar     <= '0;
            end else if (w_bar_step) begin
                r_bar_sub <= '0;
                r_bar     <= r_bar + 3'd1;
            end else begin
                r_bar_sub <= r_bar_sub + CRD_ONE;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cfg <= '0;
        end else if (i_ce && w_frame0) begin
            r_cfg <= w_cfg_live;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_de <= 1'b0;
            r_hs <= ~HS_POL;
            r_vs <= ~VS_POL;
            r_x  <= '0;
            r_y  <= '0;
            r_fs <= 1'b0;
        end else if (i_ce) begin
            r_de <= w_active;
            r_hs <= w_hs_on ? HS_POL : ~HS_POL;
            r_vs <= w_vs_on ? VS_POL : ~VS_POL;
            r_x  <= w_x;
            r_y  <= w_y;
            r_fs <= w_frame0;
        end
    end

    video_timing_gen_pattern u_pattern (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_ce     (i_ce),
        .i_active (w_active),
        .i_x      (w_x),
        .i_y      (w_y),
        .i_bar    (r_bar),
        .i_cfg    (w_cfg),
        .o_rgb    (w_rgb)
    );

    assign o_de          = r_de;
    assign o_hsync       = r_hs;
    assign o_vsync       = r_vs;
    assign o_r           = w_rgb[23:16];
    assign o_g           = w_rgb[15:8];
    assign o_b           = w_rgb[7:0];
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_frame_start = r_fs;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: directed raster checks plus randomized ce/config
// traffic, all compared against an arithmetic model of the frame.
module tb_video_timing_gen;

    localparam int IMG_W = 64;
    localparam int IMG_H = 64;
    localparam int HT    = 80;
    localparam int VT    = 68;
    localparam int FRAME = HT * VT;
    localparam int HS0   = 68;
    localparam int HS1   = 76;
    localparam int VS0   = 65;
    localparam int VS1   = 67;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ce  = 1'b0;
    logic [1:0]  psel = 2'd0;
    logic [23:0] solid = 24'h0;
    logic        mk_en = 1'b0;
    logic [9:0]  mk_x = 10'd0;
    logic [9:0]  mk_y = 10'd0;

    logic        de, hs, vs, fs;
    logic [7:0]  r, g, b;
    logic [9:0]  x, y;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    int          m_t;
    int          m_h;
    int          m_v;
    logic [47:0] m_out;
    int          c_pat;
    logic [23:0] c_solid;
    logic        c_en;
    int          c_mx;
    int          c_my;

    video_timing_gen dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_ce          (ce),
        .i_pattern_sel (psel),
        .i_solid_rgb   (solid),
        .i_marker_en   (mk_en),
        .i_marker_x    (mk_x),
        .i_marker_y    (mk_y),
        .o_de          (de),
        .o_hsync       (hs),
        .o_vsync       (vs),
        .o_r           (r),
        .o_g           (g),
        .o_b           (b),
        .o_x           (x),
        .o_y           (y),
        .o_frame_start (fs)
    );

    always #5 clk = ~clk;

    // Expected outputs for the pixel at ce-count t: {de,hs,vs,rgb,x,y,fs}.
    function automatic logic [47:0] ref_px(input int t);
        int          h, v, c;
        logic        act;
        logic [23:0] rgb;
        logic [7:0]  gv;
        logic [9:0]  xo, yo;
        h   = t % HT;
        v   = (t / HT) % VT;
        act = (h < IMG_W) && (v < IMG_H);
        rgb = 24'h0;
        if (act) begin
            if (c_en && (h == c_mx || v == c_my)) begin
                rgb = 24'hFF0000;
            end else begin
                case (c_pat)
                    0: begin
                        c   = 7 - h / (IMG_W / 8);
                        rgb = {((c & 4) != 0) ? 8'hFF : 8'h00,
                               ((c & 2) != 0) ? 8'hFF : 8'h00,
                               ((c & 1) != 0) ? 8'hFF : 8'h00};
                    end
                    1: begin
                        gv  = 8'(h % 256);
                        rgb = {gv, gv, gv};
                    end
                    2: rgb = (((h / 8) + (v / 8)) % 2 == 1) ? 24'hFFFFFF : 24'h0;
                    default: rgb = c_solid;
                endcase
            end
        end
        xo = act ? 10'(h) : 10'd0;
        yo = act ? 10'(v) : 10'd0;
        return {act, (h >= HS0 && h < HS1), (v >= VS0 && v < VS1),
                rgb, xo, yo, (h == 0 && v == 0)};
    endfunction

    task automatic chk(input string tag, input logic [47:0] got,
                       input logic [47:0] exp);
        vectors++;
        assert (got === exp) else begin
            miscompares++;
            $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic rv, input logic cv);
        rst = rv;
        ce  = cv;
        @(posedge clk);
        #1;
        cyc++;
        if (rv) begin
            m_t = 0; m_h = -1; m_v = -1; m_out = '0;
            c_pat = 0; c_solid = 24'h0; c_en = 1'b0; c_mx = 0; c_my = 0;
        end else if (cv) begin
            if (m_t % FRAME == 0) begin
                c_pat = int'(psel); c_solid = solid; c_en = mk_en;
                c_mx = int'(mk_x); c_my = int'(mk_y);
            end
            m_out = ref_px(m_t);
            m_h   = m_t % HT;
            m_v   = (m_t / HT) % VT;
            m_t++;
        end
        chk("pixel", {de, hs, vs, r, g, b, x, y, fs}, m_out);
    endtask

    task automatic run_to(input int h, input int v);
        int n;
        n = 0;
        while (!(m_h == h && m_v == v) && n < 2 * FRAME) begin
            step(1'b0, 1'b1);
            n++;
        end
        chk("pos", 48'({x, y}), 48'({10'(h), 10'(v)}));
    endtask

    initial begin
        int n, t0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        chk("rst_state", {de, hs, vs, r, g, b, x, y, fs}, 48'h0);

        step(1'b0, 1'b1);
        t0 = cyc;
        chk("first_px", 48'({fs, de, r, g, b}), 48'({2'b11, 24'hFFFFFF}));
        run_to(7, 0);
        chk("bar7_x7", 48'({r, g, b}), 48'h00FFFFFF);
        step(1'b0, 1'b1);
        chk("bar6_x8", 48'({r, g, b}), 48'h00FFFF00);
        run_to(56, 0);
        chk("bar0_x56", 48'({r, g, b}), 48'h0);

        run_to(0, 1);
        n = 0;
        while (hs !== 1'b1 && n < HT) begin step(1'b0, 1'b1); n++; end
        chk("hs_delay", 48'(n), 48'(68));
        n = 0;
        while (hs === 1'b1 && n < HT) begin step(1'b0, 1'b1); n++; end
        chk("hs_width", 48'(n), 48'(8));

        run_to(0, 2);
        n = (de === 1'b1) ? 1 : 0;
        for (int i = 1; i < HT; i++) begin
            step(1'b0, 1'b1);
            if (de === 1'b1) n++;
        end
        chk("de_per_line", 48'(n), 48'(64));

        n = 0;
        while (vs !== 1'b1 && n < 2 * FRAME) begin step(1'b0, 1'b1); n++; end
        chk("vs_start", 48'(cyc - t0), 48'(65 * HT));
        n = 0;
        while (vs === 1'b1 && n < 2 * FRAME) begin step(1'b0, 1'b1); n++; end
        chk("vs_width", 48'(n), 48'(2 * HT));
        n = 0;
        while (fs !== 1'b1 && n < 2 * FRAME) begin step(1'b0, 1'b1); n++; end
        chk("frame_period", 48'(cyc - t0), 48'(FRAME));

        run_to(0, 30);
        psel = 2'd1;
        run_to(8, 31);
        chk("no_tear", 48'({r, g, b}), 48'h00FFFF00);
        run_to(0, 0);
        chk("new_pat_fs", 48'({fs, r, g, b}), 48'({1'b1, 24'h0}));
        run_to(5, 0);
        chk("ramp_x5", 48'({r, g, b}), 48'h00050505);

        run_to(0, 10);
        psel = 2'd3; solid = 24'h123456;
        mk_en = 1'b1; mk_x = 10'd10; mk_y = 10'd20;
        run_to(0, 0);
        run_to(3, 5);
        chk("solid", 48'({r, g, b}), 48'h00123456);
        run_to(10, 5);
        chk("mark_col", 48'({r, g, b}), 48'h00FF0000);
        run_to(3, 20);
        chk("mark_row", 48'({r, g, b}), 48'h00FF0000);

        run_to(40, 40);
        step(1'b1, 1'b0);
        chk("mid_rst", {de, hs, vs, r, g, b, x, y, fs}, 48'h0);
        step(1'b0, 1'b1);
        chk("restart", 48'({fs, de, x, y}), 48'({2'b11, 20'h0}));

        for (int i = 0; i < 14000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                psel  = 2'($urandom_range(0, 3));
                solid = 24'($urandom);
                mk_en = 1'($urandom_range(0, 1));
                mk_x  = ($urandom_range(0, 3) == 0) ? 10'($urandom) :
                        10'($urandom_range(0, 79));
                mk_y  = 10'($urandom_range(0, 70));
            end
            step(($urandom_range(0, 9999) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 7) != 0) ? 1'b1 : 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
